atmospheric_light_estimator: RTL and testbench
==============================================

# atmospheric_light_estimator

Per-frame atmospheric light (A) estimator for the dehaze pipeline. Scans each incoming RGB frame, finds the pixel with the brightest dark channel (min of R, G, B), and publishes that pixel's RGB as A. It sits upstream of scene recovery with saturation correction, driving its atmospheric-light inputs and their valid. Optional temporal IIR smoothing suppresses frame-to-frame flicker.

## Interface
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- SMOOTH, 1, 1 = IIR-smooth A across frames, 0 = take each frame's A directly
- A_FLOOR, 8'd64, lower clamp applied to each output channel
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- i_r, i_g, i_b  in  8 each  pixel channels, sampled when i_valid=1
- i_valid  in  1  pixel qualifier; gaps allowed on any cycle
- i_sof  in  1  start of frame, honoured only with i_valid=1; marks the current pixel as index 0
- o_a_r, o_a_g, o_a_b  out  8 each  current A
- o_valid  out  1  high once the first full frame has produced A; sticky until reset
- o_update  out  1  one-cycle pulse when o_a_* take a new value

## Operation
- Stage 1 (accept): on i_valid, register RGB and dark = min(r,g,b).
  - Pixel counter: 0..IMG_WIDTH*IMG_HEIGHT-1, width clog2(W*H).
  - Tag each pixel first (count==0 or i_sof) and last (count==W*H-1).
  - The counter wraps to 0 after last.
  - i_sof forces the count to 0 for this pixel and discards the partial frame.
- Stage 2 (track): hold tracker {max_dark, r, g, b}.
  - A first-tagged pixel loads the tracker unconditionally.
  - Otherwise, load only if dark > max_dark (strict; ties keep the earliest pixel).
  - A last-tagged pixel loads the final tracker value into frame_a and sets a pending flag.
- Stage 3 (publish): FSM with states SCAN and UPDATE.
  - SCAN -> UPDATE when pending is set. UPDATE lasts exactly one cycle, then returns to SCAN.
  - In UPDATE, compute per channel: if first_done=0 or SMOOTH=0, a = frame_a; else a = (3*a_old + frame_a + 2) >> 2, using a 10-bit intermediate with no overflow.
  - Then apply out = max(a, A_FLOOR).
  - Load o_a_*, pulse o_update, set o_valid and first_done.
- Back-to-back frames need no bubble. The next frame's first pixel reloads the tracker independently of the publish stage.
- The tracker is never read between the last pixel and the next first pixel.
- The atmospheric-light valid consumed by scene recovery is o_valid.

## Timing
- Reset (rst=0, async): o_a_* = 0, o_valid = 0, o_update = 0. Counter, tracker, pending and first_done clear; FSM = SCAN.
- Latency: a last pixel accepted at edge N gives new o_a_* and o_update=1 after edge N+2. o_update deasserts after N+3.
- i_valid gaps stall the counter only. Pipeline tags travel with data, so gaps never corrupt frame boundaries.
- A last pixel and the next frame's first pixel on consecutive cycles are both handled.
- o_a_* hold their value between updates. Downstream may sample them on any cycle while o_valid=1.
- Reset mid-frame discards all state; the next frame starts at count 0.
- Reset during UPDATE: reset wins and o_update stays 0.
- i_sof mid-frame: the partial frame produces no update. The counter restarts, and the tracker reloads from the sof pixel.
- i_sof asserted on the natural index-0 pixel has no extra effect.

## Test plan
All cases use IMG_WIDTH=4, IMG_HEIGHT=2, SMOOTH=0, A_FLOOR=0 unless stated.
- Reset values: rst low with random stimulus -> all outputs 0. Release with no pixels -> o_valid remains 0.
- Single frame: 8 pixels, pixel 5 = (200,180,190), others (10,20,30) -> o_a = (200,180,190) two cycles after the last pixel, o_update high for one cycle, o_valid = 1.
- Tie and gaps: pixels 2 and 6 both have dark = 150 (RGB 150/160/170 and 150/250/250), with random i_valid gaps -> A = (150,160,170).
- Smoothing: SMOOTH=1. Frame 1 gives A = (100,100,100); frame 2 gives brightest pixel (200,200,200) -> o_a = (125,125,125) = (300+200+2)>>2.
- Floor and sof: A_FLOOR=64. Frame brightest pixel (30,40,50) -> o_a = (64,64,64). Then i_sof at pixel 3 of the next frame -> no o_update until 8 pixels after the sof.
- Back-to-back with reset: 3 continuous frames -> 3 o_update pulses exactly 8 accepted pixels apart. Asserting rst mid-frame 2 -> outputs 0 and o_valid = 0.

Source files
------------

// File: rtl/atmospheric_light_estimator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : atmospheric_light_estimator
// Purpose  : Per-frame atmospheric light (A) estimator for the dehaze path.
//            Finds the pixel whose dark channel min(R,G,B) is largest in each
//            frame (earliest pixel wins ties) and publishes its RGB as A,
//            optionally IIR-smoothed across frames and clamped from below.
// Ports    : clk              - sole clock, rising edge
//            rst              - asynchronous, active-low reset
//            i_r/i_g/i_b      - pixel channels, sampled when i_valid=1
//            i_valid          - pixel qualifier, gaps allowed on any cycle
//            i_sof            - start of frame (only with i_valid=1)
//            o_a_r/o_a_g/o_a_b- current atmospheric light
//            o_valid          - sticky, high once the first A was published
//            o_update         - one-cycle pulse when o_a_* take a new value
// Revision : 1.0 - initial release
// ============================================================================
module atmospheric_light_estimator #(
    parameter int          IMG_WIDTH  = 512,
    parameter int          IMG_HEIGHT = 512,
    parameter int          SMOOTH     = 1,
    parameter logic [7:0]  A_FLOOR    = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    input  logic       i_valid,
    input  logic       i_sof,
    output logic [7:0] o_a_r,
    output logic [7:0] o_a_g,
    output logic [7:0] o_a_b,
    output logic       o_valid,
    output logic       o_update
);

    localparam int c_npix  = IMG_WIDTH * IMG_HEIGHT;
    localparam int c_cnt_w = (c_npix > 1) ? $clog2(c_npix) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_npix - 1);

    typedef enum logic [0:0] {
        ST_SCAN   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Stage 1: accept pixel, compute dark channel, tag frame boundaries
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_idx;
    logic               w_first;
    logic               w_last;
    logic [7:0]         w_min_rg;
    logic [7:0]         w_dark;

    logic               r_s1_valid;
    logic               r_s1_first;
    logic               r_s1_last;
    logic [7:0]         r_s1_r;
    logic [7:0]         r_s1_g;
    logic [7:0]         r_s1_b;
    logic [7:0]         r_s1_dark;

    always_comb begin
        // A sof pixel is index 0 regardless of where the counter stood;
        // this also discards any partial frame.
        w_idx    = i_sof ? '0 : r_cnt;
        w_first  = (w_idx == '0);
        w_last   = (w_idx == c_last_idx);
        w_min_rg = (i_r < i_g) ? i_r : i_g;
        w_dark   = (w_min_rg < i_b) ? w_min_rg : i_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s1_dark  <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_s1_r     <= i_r;
                r_s1_g     <= i_g;
                r_s1_b     <= i_b;
                r_s1_dark  <= w_dark;
                r_cnt      <= w_last ? '0 : (w_idx + c_cnt_w'(1));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: running maximum of the dark channel within the frame
    // ------------------------------------------------------------------------
    logic [7:0] r_max_dark;
    logic [7:0] r_trk_r;
    logic [7:0] r_trk_g;
    logic [7:0] r_trk_b;
    logic [7:0] r_frame_r;
    logic [7:0] r_frame_g;
    logic [7:0] r_frame_b;
    logic       r_pending;

    logic       w_take;
    logic [7:0] w_trk_r;
    logic [7:0] w_trk_g;
    logic [7:0] w_trk_b;
    logic       w_consume;

    state_t     r_state;
    state_t     w_state_nxt;

    always_comb begin
        // Strict compare keeps the earliest pixel on ties.
        w_take  = r_s1_first || (r_s1_dark > r_max_dark);
        // The last pixel of a frame can itself be the winner, so frame_a is
        // captured from the tracker value as it will be after this pixel.
        w_trk_r = w_take ? r_s1_r : r_trk_r;
        w_trk_g = w_take ? r_s1_g : r_trk_g;
        w_trk_b = w_take ? r_s1_b : r_trk_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max_dark <= '0;
            r_trk_r    <= '0;
            r_trk_g    <= '0;
            r_trk_b    <= '0;
            r_frame_r  <= '0;
            r_frame_g  <= '0;
            r_frame_b  <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (r_s1_valid && w_take) begin
                r_max_dark <= r_s1_dark;
                r_trk_r    <= r_s1_r;
                r_trk_g    <= r_s1_g;
                r_trk_b    <= r_s1_b;
            end
            if (r_s1_valid && r_s1_last) begin
                r_frame_r <= w_trk_r;
                r_frame_g <= w_trk_g;
                r_frame_b <= w_trk_b;
                r_pending <= 1'b1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: publish FSM
    // ------------------------------------------------------------------------
    logic r_first_done;
    logic w_smooth_sel;

    // (3*old + new + 2) >> 2 in 10 bits cannot overflow (max 1022), then floor.
    function automatic logic [7:0] f_publish(input logic [7:0] a_old,
                                             input logic [7:0] a_new,
                                             input logic       smooth);
        logic [9:0] s;
        logic [7:0] a;
        s = {2'b00, a_old} + {1'b0, a_old, 1'b0} + {2'b00, a_new} + 10'd2;
        a = smooth ? 8'(s >> 2) : a_new;
        return (a < A_FLOOR) ? A_FLOOR : a;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_consume    = 1'b0;
        w_smooth_sel = (SMOOTH != 0) && r_first_done;
        case (r_state)
            ST_SCAN: begin
                if (r_pending) begin
                    w_state_nxt = ST_UPDATE;
                    w_consume   = 1'b1;
                end
            end
            ST_UPDATE: begin
                w_state_nxt = ST_SCAN;
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // The new A is registered on the edge that enters UPDATE, so it becomes
    // visible together with o_update two edges after the last pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_a_r        <= '0;
            o_a_g        <= '0;
            o_a_b        <= '0;
            o_valid      <= 1'b0;
            r_first_done <= 1'b0;
        end else if (w_consume) begin
            o_a_r        <= f_publish(o_a_r, r_frame_r, w_smooth_sel);
            o_a_g        <= f_publish(o_a_g, r_frame_g, w_smooth_sel);
            o_a_b        <= f_publish(o_a_b, r_frame_b, w_smooth_sel);
            o_valid      <= 1'b1;
            r_first_done <= 1'b1;
        end
    end

    assign o_update = (r_state == ST_UPDATE);

endmodule
`default_nettype wire

// File: tb/tb_atmospheric_light_estimator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_atmospheric_light_estimator
// Purpose  : Scoreboard bench for atmospheric_light_estimator. Two instances
//            share one pixel stream: one with direct A and no floor, one with
//            smoothing and a floor of 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atmospheric_light_estimator;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int SM0  = 0;
    localparam int FL0  = 0;
    localparam int SM1  = 1;
    localparam int FL1  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_r = '0, i_g = '0, i_b = '0;
    logic       i_valid = 1'b0, i_sof = 1'b0;
    logic [7:0] a0r, a0g, a0b, a1r, a1g, a1b;
    logic       v0, u0, v1, u1;

    atmospheric_light_estimator #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .SMOOTH(SM0), .A_FLOOR(8'(FL0))
    ) dut0 (
        .clk(clk), .rst(rst), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_valid(i_valid), .i_sof(i_sof),
        .o_a_r(a0r), .o_a_g(a0g), .o_a_b(a0b), .o_valid(v0), .o_update(u0)
    );

    atmospheric_light_estimator #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .SMOOTH(SM1), .A_FLOOR(8'(FL1))
    ) dut1 (
        .clk(clk), .rst(rst), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_valid(i_valid), .i_sof(i_sof),
        .o_a_r(a1r), .o_a_g(a1g), .o_a_b(a1b), .o_valid(v1), .o_update(u1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    exp_t q0[$];
    exp_t q1[$];
    pix_t frame[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cnt = 0;
    int a_old[2][3];
    bit fdone[2];

    function automatic int min3(input pix_t p);
        int m;
        m = p.r;
        if (int'(p.g) < m) m = p.g;
        if (int'(p.b) < m) m = p.b;
        return m;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        frame.delete();
        m_cnt = 0;
        for (int d = 0; d < 2; d++) begin
            fdone[d] = 1'b0;
            for (int c = 0; c < 3; c++) a_old[d][c] = 0;
        end
    endtask

    task automatic model_push(input int id, input pix_t best, input int acyc);
        int   smooth, fl, a;
        int   f[3];
        int   o[3];
        exp_t e;
        smooth = (id == 0) ? SM0 : SM1;
        fl     = (id == 0) ? FL0 : FL1;
        f[0] = best.r; f[1] = best.g; f[2] = best.b;
        for (int c = 0; c < 3; c++) begin
            if (fdone[id] && smooth != 0) a = (3 * a_old[id][c] + f[c] + 2) / 4;
            else                           a = f[c];
            o[c] = (a < fl) ? fl : a;
            a_old[id][c] = o[c];
        end
        fdone[id] = 1'b1;
        e.r = 8'(o[0]); e.g = 8'(o[1]); e.b = 8'(o[2]);
        e.cyc = acyc + 2;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic model_accept(input int r, input int g, input int b,
                                input bit sof, input int acyc);
        int   idx;
        int   best;
        pix_t p;
        idx = sof ? 0 : m_cnt;
        if (idx == 0) frame.delete();
        p.r = 8'(r); p.g = 8'(g); p.b = 8'(b);
        frame.push_back(p);
        if (idx == NPIX - 1) begin
            best = 0;
            for (int i = 1; i < frame.size(); i++)
                if (min3(frame[i]) > min3(frame[best])) best = i;
            model_push(0, frame[best], acyc);
            model_push(1, frame[best], acyc);
            m_cnt = 0;
        end else begin
            m_cnt = idx + 1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Drivers (entered and left at posedge + #1)
    // ------------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            i_valid = 1'b0;
            i_sof   = 1'($urandom_range(0, 1));
            i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
            @(posedge clk); #1;
        end
        i_sof = 1'b0;
    endtask

    task automatic pix(input int r, input int g, input int b,
                       input bit sof, input int maxgap);
        if (maxgap > 0) idle($urandom_range(0, maxgap));
        i_valid = 1'b1;
        i_sof   = sof;
        i_r = 8'(r); i_g = 8'(g); i_b = 8'(b);
        model_accept(r, g, b, sof, cyc + 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({a0r, a0g, a0b, v0, u0, a1r, a1g, a1b, v1, u1} !== '0)
            $display("FAIL %s: got dut0=%h/%h/%h v=%b u=%b dut1=%h/%h/%h v=%b u=%b required all zero",
                     name, a0r, a0g, a0b, v0, u0, a1r, a1g, a1b, v1, u1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_clear();
        repeat (n) begin
            i_valid = 1'($urandom_range(0, 1));
            i_sof   = 1'($urandom_range(0, 1));
            i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
            @(negedge clk);
            check_zero_outputs("reset_outputs");
            @(posedge clk); #1;
        end
        rst     = 1'b1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic idle_chk_invalid(input int n);
        repeat (n) begin
            i_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (v0 !== 1'b0 || v1 !== 1'b0)
                $display("FAIL valid_before_frame: got v0=%b v1=%b required 0", v0, v1);
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    logic        prev_u[2];
    logic [23:0] hold[2];

    task automatic mon(input int id, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic v, input logic u);
        exp_t e;
        bit   empty;
        if (u) begin
            checks++;
            empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                errors++;
                $display("FAIL unexpected_update dut%0d: got pulse at cycle %0d with A=%h/%h/%h required none",
                         id, cyc, r, g, b);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                checks++;
                if ({r, g, b} !== {e.r, e.g, e.b}) begin
                    errors++;
                    $display("FAIL a_value dut%0d: got %0d/%0d/%0d required %0d/%0d/%0d",
                             id, r, g, b, e.r, e.g, e.b);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL update_latency dut%0d: got cycle %0d required %0d", id, cyc, e.cyc);
                end
                checks++;
                if (v !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_at_update dut%0d: got %b required 1", id, v);
                end
            end
        end
        if (prev_u[id]) begin
            checks++;
            if (u) begin
                errors++;
                $display("FAIL update_width dut%0d: got high 2 cycles required 1", id);
            end
        end else if (!u && v) begin
            checks++;
            if ({r, g, b} !== hold[id]) begin
                errors++;
                $display("FAIL a_hold dut%0d: got %h required %h", id, {r, g, b}, hold[id]);
            end
        end
        prev_u[id] = u;
        hold[id]   = {r, g, b};
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, a0r, a0g, a0b, v0, u0);
            mon(1, a1r, a1g, a1b, v1, u1);
        end else begin
            for (int d = 0; d < 2; d++) begin
                prev_u[d] = 1'b0;
                hold[d]   = '0;
            end
        end
    end

    // check_zero_outputs is counted in the same error variable
    always @(negedge clk) begin
        if (!rst && {a0r, a0g, a0b, v0, u0, a1r, a1g, a1b, v1, u1} !== '0)
            errors++;
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_u[d] = 1'b0;
            hold[d]   = '0;
        end
        model_clear();
        @(posedge clk); #1;

        // Reset with random stimulus, then idle with no pixels
        do_reset(5);
        idle_chk_invalid(6);

        // Single frame: pixel 5 brightest
        for (int p = 0; p < NPIX; p++)
            if (p == 5) pix(200, 180, 190, p == 0, 0);
            else        pix(10, 20, 30, p == 0, 0);
        idle(5);

        // Tie at dark=150 with random gaps; earliest (pixel 2) wins
        for (int p = 0; p < NPIX; p++)
            if (p == 2)      pix(150, 160, 170, p == 0, 3);
            else if (p == 6) pix(150, 250, 250, p == 0, 3);
            else pix($urandom_range(0, 149), $urandom_range(0, 149), $urandom_range(0, 149), p == 0, 3);
        idle(5);

        // Smoothing from a clean start: 100 then 200 -> 125 on the smoothed instance
        do_reset(2);
        for (int p = 0; p < NPIX; p++)
            if (p == 1) pix(100, 100, 100, p == 0, 0);
            else        pix(50, 60, 70, p == 0, 0);
        for (int p = 0; p < NPIX; p++)
            if (p == 4) pix(200, 200, 200, 1'b0, 1);
            else        pix(10, 10, 10, 1'b0, 1);
        idle(5);

        // Floor from a clean start, then sof at pixel 3 of the next frame
        do_reset(2);
        for (int p = 0; p < NPIX; p++)
            if (p == 6) pix(30, 40, 50, p == 0, 0);
            else        pix(1, 2, 3, p == 0, 0);
        idle(3);
        for (int p = 0; p < 3 + NPIX; p++)
            pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), p == 3, 1);
        idle(5);

        // Random frames, gaps, occasional mid-frame sof
        for (int p = 0; p < 6 * NPIX; p++)
            pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 9) == 0), 2);
        idle(5);

        // Three back-to-back frames, no gaps
        for (int p = 0; p < 3 * NPIX; p++)
            pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), p == 0, 0);
        idle(5);

        // Reset in the middle of the second of two frames
        for (int p = 0; p < NPIX + 3; p++)
            pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), p == 0, 0);
        do_reset(3);
        idle_chk_invalid(3);

        // After reset a frame without sof starts at index 0
        for (int p = 0; p < NPIX; p++)
            pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1);
        idle(6);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_updates: got pending dut0=%0d dut1=%0d required 0/0",
                     q0.size(), q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
